// File: rtl/d_wbuf.sv
// Write buffer between the write-through D-cache and memory: stores are queued and acked at once,
// drained in order; misses read memory. Define WBUF_FWD_EN for store-to-load forwarding.
module d_wbuf #(
    parameter int unsigned A_WIDTH    = 32,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] c_a,
    input  logic [31:0]        c_din,
    output logic [31:0]        c_dout,
    input  logic               c_strobe,
    input  logic               c_rw,
    output logic               c_ready,
    output logic [A_WIDTH-1:0] mem_a,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic               mem_strobe,
    output logic               mem_rw,
    input  logic               mem_ready,
    output logic               wb_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t state, state_nxt;

    logic [A_WIDTH-1:0]    addr_q [DEPTH];
    logic [31:0]           data_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    logic full, empty, rd_req, push, pop, read_done;
    logic fwd_hit;
    logic [31:0] fwd_data;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign rd_req    = c_strobe & ~c_rw;
    assign push      = ~rst & c_strobe & c_rw & ~full;
    assign pop       = (state == WRITE) & mem_ready;
    assign read_done = ~rst & (state == READ) & mem_ready;

`ifdef WBUF_FWD_EN
    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        logic [DEPTH_LOG2-1:0] idx;
        logic                  hit;
        idx      = '0;
        hit      = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + DEPTH_LOG2'(i);
            if (i < 32'(count) && addr_q[idx] == c_a) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
        fwd_hit = hit & rd_req & ~rst & (state != READ);
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef WBUF_FWD_EN
                if (rd_req && !fwd_hit)      state_nxt = READ;
                else if (!empty && !fwd_hit) state_nxt = WRITE;
`else
                if (!empty)                  state_nxt = WRITE;
                else if (rd_req)             state_nxt = READ;
`endif
            end
            WRITE:   if (mem_ready) state_nxt = IDLE;
            READ:    if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        c_ready  = push | read_done | fwd_hit;
        c_dout   = '0;
        if (read_done)    c_dout = mem_rdata;
        else if (fwd_hit) c_dout = fwd_data;
        wb_empty = empty & (state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_a      <= '0;
            mem_wdata  <= '0;
            mem_strobe <= 1'b0;
            mem_rw     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;

            if (state == IDLE && state_nxt == WRITE) begin
                mem_a      <= addr_q[rd_ptr];
                mem_wdata  <= data_q[rd_ptr];
                mem_strobe <= 1'b1;
                mem_rw     <= 1'b1;
            end else if (state == IDLE && state_nxt == READ) begin
                mem_a      <= c_a;
                mem_strobe <= 1'b1;
                mem_rw     <= 1'b0;
            end else if (pop || read_done) begin
                mem_strobe <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= c_a;
            data_q[wr_ptr] <= c_din;
        end
    end

endmodule

// File: tb/tb_d_wbuf.sv
// Directed self-checking bench for d_wbuf; the forwarding scenario runs when WBUF_FWD_EN is defined.
module tb_d_wbuf;

    logic        clk, rst;
    logic [31:0] c_a, c_din, c_dout;
    logic        c_strobe, c_rw, c_ready;
    logic [31:0] mem_a, mem_wdata, mem_rdata;
    logic        mem_strobe, mem_rw, wb_empty;
    logic        mem_ready_r, auto_ready;
    wire logic   mem_ready;

    assign mem_ready = auto_ready ? mem_strobe : mem_ready_r;

    d_wbuf #(.A_WIDTH(32), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst),
        .c_a(c_a), .c_din(c_din), .c_dout(c_dout),
        .c_strobe(c_strobe), .c_rw(c_rw), .c_ready(c_ready),
        .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_ready(mem_ready),
        .wb_empty(wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wlog[$];
    int          rd_issue_cnt = 0;
    int          strobe_cyc = 0;
    int          rd_wlog_at_issue = 0;
    logic [31:0] rd_addr = '0;
    logic        rd_prev = 1'b0;

    // Observe completed memory writes and read issues at the clock edge.
    always @(posedge clk) begin
        if (mem_strobe && mem_rw && mem_ready) wlog.push_back(mem_a);
        if (mem_strobe) strobe_cyc <= strobe_cyc + 1;
        if (mem_strobe && !mem_rw && !rd_prev) begin
            rd_issue_cnt     <= rd_issue_cnt + 1;
            rd_addr          <= mem_a;
            rd_wlog_at_issue <= wlog.size();
        end
        rd_prev <= mem_strobe && !mem_rw;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        c_strobe = 1'b1; c_rw = 1'b1; c_a = a; c_din = d;
    endtask

    task automatic read(input logic [31:0] a);
        c_strobe = 1'b1; c_rw = 1'b0; c_a = a;
    endtask

    // kind 0: mem_strobe, 1: c_ready, 2: wb_empty; leaves us at the negedge where it held.
    task automatic wait_for(input int kind, input string tag, input int lim);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < lim && !hit; n++) begin
            @(negedge clk);
            case (kind)
                0:       hit = mem_strobe;
                1:       hit = c_ready;
                default: hit = wb_empty;
            endcase
            if (!hit) step();
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst = 1'b1; auto_ready = 1'b0; mem_ready_r = 1'b0; mem_rdata = '0;
        c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h10; c_din = 32'h1;

        // Reset: outputs idle even with a store presented
        @(negedge clk);
        check("rst_c_ready", 32'(c_ready), 32'd0);
        check("rst_wb_empty", 32'(wb_empty), 32'd1);
        check("rst_mem_strobe", 32'(mem_strobe), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        step(); rst = 1'b0; c_strobe = 1'b0;

        // 1: single store, memory acks after a few cycles
        step(); store(32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_c_ready", 32'(c_ready), 32'd1);
        check("t1_c_dout", c_dout, 32'd0);
        step(); c_strobe = 1'b0;
        wait_for(0, "t1_strobe_seen", 5);
        check("t1_mem_rw", 32'(mem_rw), 32'd1);
        check("t1_mem_a", mem_a, 32'h100);
        check("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step(); @(negedge clk);
        check("t1_hold_strobe", 32'(mem_strobe), 32'd1);
        check("t1_hold_a", mem_a, 32'h100);
        step(); mem_ready_r = 1'b1; @(negedge clk);
        check("t1_ack_strobe", 32'(mem_strobe), 32'd1);
        step(); mem_ready_r = 1'b0; @(negedge clk);
        check("t1_done_strobe", 32'(mem_strobe), 32'd0);
        check("t1_wb_empty", 32'(wb_empty), 32'd1);

        // 2: five back-to-back stores into a 4-deep buffer
        wlog.delete();
        for (int k = 0; k < 5; k++) begin
            step(); store(32'(4 * k), 32'h1000 + 32'(k));
            @(negedge clk);
            check(k < 4 ? "t2_accept" : "t2_full_stall", 32'(c_ready), k < 4 ? 32'd1 : 32'd0);
        end
        step(); @(negedge clk);
        check("t2_full_hold", 32'(c_ready), 32'd0);
        step(); mem_ready_r = 1'b1; @(negedge clk);
        check("t2_full_pop_cycle", 32'(c_ready), 32'd0);
        step(); mem_ready_r = 1'b0; @(negedge clk);
        check("t2_accept_5th", 32'(c_ready), 32'd1);
        step(); c_strobe = 1'b0; auto_ready = 1'b1;
        wait_for(2, "t2_drained", 40);
        check("t2_wlog_size", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < wlog.size() && i < 5; i++)
            check("t2_order", wlog[i], 32'(4 * i));

`ifndef WBUF_FWD_EN
        // 3: read waits for both older stores to drain
        wlog.delete(); snap = rd_issue_cnt; mem_rdata = 32'h12345678;
        step(); store(32'h40, 32'hA);
        step(); store(32'h44, 32'hB);
        step(); read(32'h200);
        wait_for(1, "t3_read_done", 30);
        check("t3_c_dout", c_dout, 32'h12345678);
        step(); c_strobe = 1'b0;
        @(negedge clk);
        check("t3_wlog_size", 32'(wlog.size()), 32'd2);
        check("t3_writes_before_read", 32'(rd_wlog_at_issue), 32'd2);
        check("t3_rd_addr", rd_addr, 32'h200);
        check("t3_rd_issues", 32'(rd_issue_cnt - snap), 32'd1);
`else
        // 4: forwarding returns the youngest matching store without a memory read
        auto_ready = 1'b0; snap = rd_issue_cnt;
        step(); store(32'h40, 32'h11);
        step(); store(32'h40, 32'h22);
        step(); read(32'h40);
        @(negedge clk);
        check("t4_c_ready", 32'(c_ready), 32'd1);
        check("t4_c_dout", c_dout, 32'h22);
        step(); c_strobe = 1'b0;
        step(); @(negedge clk);
        check("t4_no_mem_read", 32'(rd_issue_cnt - snap), 32'd0);
        step(); auto_ready = 1'b1;
        wait_for(2, "t4_drained", 30);
`endif

        // 5: read on empty buffer with a zero-wait memory
        auto_ready = 1'b1; mem_rdata = 32'hCAFEF00D; snap = rd_issue_cnt;
        step(); read(32'h80);
        @(negedge clk);
        check("t5_not_ready_c0", 32'(c_ready), 32'd0);
        step(); @(negedge clk);
        check("t5_ready_c1", 32'(c_ready), 32'd1);
        check("t5_c_dout", c_dout, 32'hCAFEF00D);
        step(); c_strobe = 1'b0;
        step(); @(negedge clk);
        check("t5_single_read", 32'(rd_issue_cnt - snap), 32'd1);
        check("t5_rd_addr", rd_addr, 32'h80);

        // 6: reset while writing with three entries buffered
        auto_ready = 1'b0; mem_ready_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); store(32'h300 + 32'(4 * k), 32'h5000 + 32'(k));
        end
        step(); c_strobe = 1'b0;
        wait_for(0, "t6_in_write", 5);
        step(); rst = 1'b1; #1;
        check("t6_rst_strobe", 32'(mem_strobe), 32'd0);
        check("t6_rst_wb_empty", 32'(wb_empty), 32'd1);
        step(); rst = 1'b0; auto_ready = 1'b1; wlog.delete(); snap = strobe_cyc;
        repeat (8) step();
        @(negedge clk);
        check("t6_no_stale_writes", 32'(wlog.size()), 32'd0);
        check("t6_no_strobe", 32'(strobe_cyc - snap), 32'd0);
        check("t6_wb_empty", 32'(wb_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/d_wbuf.md
Name: d_wbuf

Overview:
Write buffer between the write-through data cache and the memory interface. It absorbs the cache's write-through stores into a small FIFO and acknowledges them immediately. It drains the FIFO to memory in order. Cache-miss reads go to memory only after the FIFO is ordered correctly with respect to buffered stores.

Parameters:
A_WIDTH, 32, address width in bits
DEPTH_LOG2, 2, log2 of FIFO depth; DEPTH = 1<<DEPTH_LOG2 entries of {addr, data}

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
c_a  input  A_WIDTH  request address from cache
c_din  input  32  store data from cache
c_dout  output  32  read data to cache
c_strobe  input  1  request valid; held with stable a/din/rw until c_ready
c_rw  input  1  0: read, 1: write
c_ready  output  1  request complete this cycle
mem_a  output  A_WIDTH  memory address, registered
mem_wdata  output  32  memory write data, registered
mem_rdata  input  32  memory read data, valid when mem_ready
mem_strobe  output  1  memory request, registered
mem_rw  output  1  0: read, 1: write, registered
mem_ready  input  1  one-cycle completion pulse for current memory request
wb_empty  output  1  FIFO holds no entries and FSM is IDLE

Behaviour:
- Reset (async, rst=1):
  - wr_ptr = rd_ptr = count = 0; FSM = IDLE.
  - mem_strobe = 0, mem_rw = 0, mem_a = 0, mem_wdata = 0.
  - c_ready = 0 and wb_empty = 1 while reset is asserted.
  - Reset mid-transaction discards all buffered stores and any in-flight memory request.
- FIFO:
  - count is DEPTH_LOG2+1 bits; full = (count == DEPTH); empty = (count == 0).
  - Pointers wrap modulo DEPTH.
- Write accept (combinational):
  - c_ready = 1 when c_strobe & c_rw & ~full; entry {c_a, c_din} is pushed at that clock edge.
  - Full blocks the push even if a pop occurs the same cycle; the write is accepted the next cycle.
  - Back-to-back stores: one push per cycle.
  - Same address: no merging; every store is pushed.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - If ~empty (and no read has priority, see Optional Feature): load mem_a/mem_wdata from the head entry, set mem_strobe=1, mem_rw=1, go to WRITE.
  - Else if empty & c_strobe & ~c_rw: load mem_a=c_a, set mem_strobe=1, mem_rw=0, go to READ.
  - Else stay; mem_strobe=0.
- WRITE:
  - Hold mem_* stable until mem_ready.
  - On mem_ready: pop the head (rd_ptr+1, count-1), clear mem_strobe, return to IDLE.
  - Simultaneous push and pop leaves count unchanged.
- READ:
  - Hold until mem_ready.
  - On mem_ready: c_ready=1 and c_dout=mem_rdata combinationally that cycle; clear mem_strobe; return to IDLE.
  - c_dout = 0 whenever c_ready is not from a read.
- Reads never complete while an older buffered store to any address is undrained (without feature).
- Latency:
  - Write: 0 cycles to c_ready when not full.
  - Read on empty buffer: mem_strobe rises 1 cycle after c_strobe; c_ready on the cycle mem_ready arrives (≥1 cycle after c_strobe).
- A read held across cycles is issued once. After its c_ready, a read strobe on the following cycle is a new request.

Optional Feature:
Macro WBUF_FWD_EN.
- Defined:
  - Store-to-load forwarding: a read whose c_a equals (all A_WIDTH bits) the address of any valid entry completes combinationally with c_ready=1 and c_dout = data of the youngest matching entry. No memory access is made; FSM state is unchanged.
  - A non-matching read in IDLE has priority over draining and issues to memory even when the FIFO is non-empty.
- Undefined: no comparators; reads wait for an empty FIFO as above.

Test Plan:
1. Store 0x100=0xDEADBEEF, mem_ready 3 cycles later → c_ready same cycle; mem_strobe=1, mem_rw=1, mem_a=0x100, mem_wdata=0xDEADBEEF from the next cycle until mem_ready; then wb_empty=1.
2. DEPTH=4, 5 back-to-back stores 0x0..0x10, mem_ready held 0 → stores 1–4 get c_ready; 5th stalls until the first pop, then is accepted; memory sees addresses 0x0,0x4,0x8,0xC,0x10 in order.
3. Without WBUF_FWD_EN: stores to 0x40, 0x44, then read 0x200 → mem read of 0x200 starts only after both writes complete; c_dout = mem_rdata (0x12345678).
4. With WBUF_FWD_EN, mem_ready held 0: stores 0x40=0x11, 0x40=0x22, read 0x40 → c_ready in the same cycle, c_dout=0x22, no mem read request.
5. Empty buffer, mem_ready driven combinationally from mem_strobe, read 0x80 → c_ready exactly 1 cycle after c_strobe, single mem read.
6. rst pulsed while in WRITE with 3 entries → mem_strobe=0 immediately, wb_empty=1; after release, no stale writes issued.
